// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: 64x128-bit main memory with fixed latency, block reads, masked word writes and access statistics
module main_memory_ctrl #(
  parameter int LATENCY = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isLock,
  input  logic             isMemRead,
  input  logic [9:0]       address,
  input  logic [127:0]     memWriteData,
  input  logic [3:0]       isDirty,
  output logic [127:0]     memReadData,
  output logic             memReady,
  output logic             memBusy,
  output logic             reqDropped,
  output logic [CNT_W-1:0] readCount,
  output logic [CNT_W-1:0] writeCount
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;
  typedef logic [0:255][31:0] memT;
  function automatic memT initMem();
    memT m;
    for (int i = 0; i < 256; i++) m[i] = 32'(i);
    return m;
  endfunction
  memT mem = initMem();
  stateT state, nextState;
  logic lockQ, req, finish, opRead, unusedBits;
  logic [5:0] blk;
  logic [31:0] opData;
  logic [3:0] opMask, cnt;
  assign req = lockQ & ~isLock;
  assign finish = state == ACCESS && cnt == 4'd0;
  assign memReady = state == DONE;
  assign memBusy = state != IDLE;
  assign unusedBits = ^{address[3:0], memWriteData[127:32]};
  // next-state: accept in IDLE, count down in ACCESS, single DONE cycle
  always_comb begin
    nextState = state;
    nextState = state == IDLE ? (req ? ACCESS : IDLE) : state == ACCESS ? (finish ? DONE : ACCESS) : IDLE;
  end
  // state, request capture, read data return and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lockQ <= 1'b1;
      cnt <= '0;
      opRead <= 1'b0;
      blk <= '0;
      opData <= '0;
      opMask <= '0;
      memReadData <= '0;
      reqDropped <= 1'b0;
      readCount <= '0;
      writeCount <= '0;
    end else begin
      state <= nextState;
      lockQ <= isLock;
      if (state == IDLE && req) begin
        opRead <= isMemRead;
        blk <= address[9:4];
        opData <= memWriteData[31:0];
        opMask <= isDirty;
        cnt <= 4'(LATENCY - 1);
      end
      if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (finish && opRead) memReadData <= mem[{blk, 2'b00} +: 4];
      if (finish && opRead) readCount <= readCount + CNT_W'(readCount != '1);
      if (finish && !opRead) writeCount <= writeCount + CNT_W'(writeCount != '1);
      if (state != IDLE && req) reqDropped <= 1'b1;
    end
  end
  // array update at completion of a write; reset deliberately leaves contents alone
  always_ff @(posedge clk) begin
    if (!rst && finish && !opRead)
      for (int k = 0; k < 4; k++)
        if (opMask[k]) mem[{blk, k[1:0]}] <= opData;
  end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: directed and randomized checks of main_memory_ctrl against a cycle-timing reference model
module tb_main_memory_ctrl;
  localparam int LAT = 3;
  logic clk = 0;
  logic rst = 1, rstB = 1;
  logic isLock = 1, isLockB = 1, isMemRead = 0;
  logic [9:0] address = '0;
  logic [127:0] memWriteData = '0;
  logic [3:0] isDirty = '0;
  logic [127:0] memReadData, dataB;
  logic memReady, memBusy, reqDropped, readyB, busyB, droppedB;
  logic [15:0] readCount, writeCount;
  logic [1:0] rcB, wcB;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  main_memory_ctrl #(.LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .isLock(isLock), .isMemRead(isMemRead), .address(address),
    .memWriteData(memWriteData), .isDirty(isDirty), .memReadData(memReadData), .memReady(memReady),
    .memBusy(memBusy), .reqDropped(reqDropped), .readCount(readCount), .writeCount(writeCount));

  main_memory_ctrl #(.LATENCY(1), .CNT_W(2)) dutB (
    .clk(clk), .rst(rstB), .isLock(isLockB), .isMemRead(isMemRead), .address(address),
    .memWriteData(memWriteData), .isDirty(isDirty), .memReadData(dataB), .memReady(readyB),
    .memBusy(busyB), .reqDropped(droppedB), .readCount(rcB), .writeCount(wcB));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: word array plus "age" of the request in flight (-1 = idle)
  logic [31:0] w [256];
  int mAge = -1, mRc = 0, mWc = 0, cBlk = 0;
  bit mPrev = 1, mDrop = 0, mReq = 0, cRd = 0;
  logic [127:0] mData = '0;
  logic [31:0] cD = '0;
  logic [3:0] cM = '0;
  initial for (int i = 0; i < 256; i++) w[i] = 32'(i);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAge = -1; mPrev = 1; mData = '0; mRc = 0; mWc = 0; mDrop = 0;
    end else begin
      mReq = mPrev && !isLock;
      mPrev = isLock;
      if (mAge >= 0) begin
        if (mReq) mDrop = 1;
        mAge++;
        if (mAge == LAT) begin
          if (cRd) begin
            mData = {w[4*cBlk], w[4*cBlk+1], w[4*cBlk+2], w[4*cBlk+3]};
            if (mRc < 65535) mRc++;
          end else begin
            for (int k = 0; k < 4; k++) if (cM[k]) w[4*cBlk+k] = cD;
            if (mWc < 65535) mWc++;
          end
        end else if (mAge > LAT) mAge = -1;
      end else if (mReq) begin
        mAge = 0; cRd = isMemRead; cBlk = int'(address[9:4]); cD = memWriteData[31:0]; cM = isDirty;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    check("busy", memBusy, mAge >= 0);
    check("ready", memReady, mAge == LAT);
    check("rdata", memReadData, mData);
    check("rcount", readCount, 128'(mRc));
    check("wcount", writeCount, 128'(mWc));
    check("dropped", reqDropped, mDrop);
  end

  task automatic access(input bit sel, input bit rd, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int lat, output logic [127:0] q);
    isMemRead = rd; address = a; isDirty = m;
    memWriteData = {$urandom, $urandom, $urandom, d};
    if (sel) isLockB = 0; else isLock = 0;
    @(negedge clk);
    isLock = 1; isLockB = 1;
    address = 10'($urandom); memWriteData = {$urandom, $urandom, $urandom, $urandom};
    isDirty = 4'($urandom); isMemRead = 1'($urandom);
    lat = 0;
    while (!(sel ? readyB : memReady) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    q = sel ? dataB : memReadData;
    @(negedge clk);
  endtask

  initial begin
    int lat, pulses;
    logic [127:0] q;
    repeat (2) @(negedge clk);
    check("rst busy", memBusy, 0);
    check("rst ready", memReady, 0);
    check("rst rdata", memReadData, 0);
    rst = 0;
    @(negedge clk);
    access(0, 1, 10'h034, 0, 0, lat, q);
    check("t1 lat", lat, 3);
    check("t1 data", q, {32'd12, 32'd13, 32'd14, 32'd15});
    check("t1 rc", readCount, 1);
    access(0, 0, 10'h034, 32'hDEADBEEF, 4'b0010, lat, q);
    check("t2 wlat", lat, 3);
    check("t2 hold", memReadData, {32'd12, 32'd13, 32'd14, 32'd15});
    check("t2 wc", writeCount, 1);
    check("t2 rc", readCount, 1);
    access(0, 1, 10'h034, 0, 0, lat, q);
    check("t2 data", q, {32'd12, 32'hDEADBEEF, 32'd14, 32'd15});
    isMemRead = 1; address = 10'h034; isLock = 0;
    @(negedge clk); isLock = 1;
    @(negedge clk); isLock = 0;
    @(negedge clk); isLock = 1;
    pulses = 0;
    repeat (8) begin
      if (memReady) pulses++;
      @(negedge clk);
    end
    check("t3 pulses", pulses, 1);
    check("t3 dropped", reqDropped, 1);
    check("t3 rc", readCount, 3);
    access(0, 0, 10'h3F0, 32'h12345678, 4'b0000, lat, q);
    check("t4 wc", writeCount, 2);
    access(0, 1, 10'h3F0, 0, 0, lat, q);
    check("t4 data", q, {32'd252, 32'd253, 32'd254, 32'd255});
    check("t4 dropped", reqDropped, 1);
    isMemRead = 1; address = 10'h000; isLock = 0;
    @(negedge clk); isLock = 1;
    @(negedge clk);
    rst = 1;
    #1;
    check("t5 busy", memBusy, 0);
    check("t5 ready", memReady, 0);
    check("t5 rdata", memReadData, 0);
    check("t5 rc", readCount, 0);
    check("t5 wc", writeCount, 0);
    check("t5 dropped", reqDropped, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (memReady) pulses++;
    end
    check("t5 nopulse", pulses, 0);
    access(0, 1, 10'h000, 0, 0, lat, q);
    check("t5 data", q, {32'd0, 32'd1, 32'd2, 32'd3});
    access(0, 1, 10'h034, 0, 0, lat, q);
    check("t5 kept", q, {32'd12, 32'hDEADBEEF, 32'd14, 32'd15});
    rstB = 0;
    @(negedge clk);
    access(1, 1, 10'h000, 0, 0, lat, q);
    check("t6 lat0", lat, 1);
    check("t6 data0", q, {32'd0, 32'd1, 32'd2, 32'd3});
    access(1, 1, 10'h010, 0, 0, lat, q);
    check("t6 lat1", lat, 1);
    check("t6 data1", q, {32'd4, 32'd5, 32'd6, 32'd7});
    access(1, 1, 10'h020, 0, 0, lat, q);
    check("t6 rc3", rcB, 3);
    access(1, 1, 10'h030, 0, 0, lat, q);
    check("t6 sat", rcB, 3);
    check("t6 wc", wcB, 0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 150) == 0;
      isLock = $urandom_range(0, 2) != 0;
      isMemRead = 1'($urandom);
      address = {3'b000, 7'($urandom)};
      memWriteData = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
        0: isDirty = 4'b0000;
        1: isDirty = 4'b0001;
        2: isDirty = 4'b0010;
        3: isDirty = 4'b0100;
        default: isDirty = 4'b1000;
      endcase
    end
    rst = 0; isLock = 1;
    repeat (8) @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Clocked main-memory model and controller that sits directly downstream of the L1 cache.
- Accepts single-block read requests and single-word write-through requests from the cache over the isLock pulse handshake.
- Models a fixed access latency and returns whole 128-bit blocks.
- Tracks read/write access counts and flags requests dropped while busy, for cache performance experiments.

Parameters:
LATENCY, 3, access latency in clk cycles from request acceptance to memReady (legal range 1..15)
CNT_W, 16, width of the saturating access counters

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
isLock  input  1  request strobe from cache; a 1->0 transition requests an access
isMemRead  input  1  1 = block read, 0 = word write; sampled at acceptance
address  input  10  byte address; [9:4] block index, [3:2] word offset; [1:0] ignored
memWriteData  input  128  write data; only [31:0] is used
isDirty  input  4  one-hot write lane mask; bit k selects word offset k
memReadData  output  128  block returned by the last completed read
memReady  output  1  one-cycle pulse when an access completes
memBusy  output  1  high while an access is in progress
reqDropped  output  1  sticky flag; a request arrived while busy
readCount  output  CNT_W  completed reads, saturating
writeCount  output  CNT_W  completed writes, saturating

Behaviour:
- Storage: 64 blocks x 128 bits (256 words). Word k of a block occupies bits [127-32k : 96-32k], so offset 0 is [127:96].
- Array init at time zero: each word holds its word address. Word address = address[9:2], so block b = {4b, 4b+1, 4b+2, 4b+3}.
- rst never modifies the array.
- Reset values: memReadData=0, memReady=0, memBusy=0, reqDropped=0, readCount=0, writeCount=0, state=IDLE, lock_q=1.
- Edge detect: lock_q is a registered copy of isLock. A request is seen on a rising clk edge where lock_q==1 and isLock==0.
- A strobe pulse narrower than one clk period may be missed. The cache must hold isLock low for at least one clk edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On a request, capture isMemRead, address[9:2], memWriteData[31:0] and isDirty.
  - Load cnt=LATENCY-1 and go to ACCESS.
- ACCESS:
  - If cnt!=0: decrement cnt.
  - If cnt==0, perform the operation on this edge and go to DONE.
  - Read: memReadData <= array[block]; readCount++.
  - Write: for each set bit k of the captured mask, word k <= captured data; writeCount++. A mask of 0 leaves the array unchanged but is still counted.
- DONE: memReady=1 for exactly this cycle, then IDLE on the next edge.
- Latency: memReady is high in the cycle after edge E0+LATENCY, where E0 is the accepting edge. A back-to-back request may be accepted in the IDLE cycle that follows.
- memBusy=1 in ACCESS and DONE, 0 in IDLE. It is registered and rises in the cycle after acceptance.
- memReadData holds its value until the next completed read. Writes never change it.
- Request detected in ACCESS or DONE: the request is ignored, and reqDropped is set and stays at 1 until rst.
- Inputs after capture: changes to address, data or mask during ACCESS do not affect the operation in flight.
- Counters stop at 2^CNT_W-1; no wrap.
- rst asserted mid-ACCESS: abort immediately, array untouched, counters cleared, all outputs at reset values.
- Request coinciding with rst deassertion: ignored, because lock_q is forced to 1 during reset.

Test Plan:
1. Reset, then isLock 1->0 with isMemRead=1, address=10'h034. memBusy rises; memReady pulses exactly 3 cycles after the accepting edge with memReadData={32'd12,32'd13,32'd14,32'd15}; readCount=1.
2. Write request: address=10'h034, memWriteData[31:0]=32'hDEADBEEF, isDirty=4'b0010. After memReady, read 10'h034 and expect {32'd12,32'hDEADBEEF,32'd14,32'd15}; writeCount=1, readCount=1; memReadData unchanged between the write and the read.
3. Second isLock falling edge one cycle after acceptance -> ignored; reqDropped=1 and stays 1; only one memReady pulse; counts increase by 1.
4. Write with isDirty=4'b0000 to 10'h3F0 -> writeCount increments; a read of 10'h3F0 returns {32'd252,32'd253,32'd254,32'd255}.
5. Assert rst two cycles into a read of 10'h000 -> memBusy=0, memReady never pulses, memReadData=0, counters=0; a later read returns {0,1,2,3}.
6. Instantiate with LATENCY=1 and issue back-to-back reads of blocks 0 and 1 -> memReady pulses 1 cycle after each acceptance; data {0,1,2,3} then {4,5,6,7}.
